// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined ALU with accumulator, carry chain, flags, optional saturation and valid/ready on both sides
module alu_pipe #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_PASS = 3'b101,
    OP_ADC  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_t              op_q, op_d;
  logic             acc_sel_q, acc_sel_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d, acc_q, acc_d;
  logic             c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic             carry_q, carry_d;
  logic             adv2, in_fire, xfer, is_add, is_sub;
  logic [WIDTH-1:0] opa, y_n;
  logic [WIDTH:0]   add_raw, sub_raw, raw;
  logic             c_n, v_n;
  always_comb begin
    adv2       = !s2_valid_q | out_ready;
    in_ready   = !s1_valid_q | adv2;
    in_fire    = in_valid & in_ready;
    xfer       = s1_valid_q & adv2;
    s1_valid_d = in_fire | (s1_valid_q & !adv2);
    a_d        = in_fire ? a : a_q;
    b_d        = in_fire ? b : b_q;
    op_d       = in_fire ? op_t'(op) : op_q;
    acc_sel_d  = in_fire ? acc_sel : acc_sel_q;
    // operand A is sampled from the accumulator at the s1->s2 edge so chained ops see the previous result
    opa        = acc_sel_q ? acc_q : a_q;
    is_add     = (op_q == OP_ADD) | (op_q == OP_ADC);
    is_sub     = op_q == OP_SUB;
    add_raw    = {1'b0, opa} + {1'b0, b_q} + {{WIDTH{1'b0}}, (op_q == OP_ADC) & carry_q};
    sub_raw    = {1'b0, opa} - {1'b0, b_q};
    raw        = is_sub ? sub_raw : add_raw;
    c_n        = (is_add | is_sub) & raw[WIDTH];
    v_n        = is_add ? (opa[WIDTH-1] == b_q[WIDTH-1]) & (raw[WIDTH-1] != opa[WIDTH-1]) :
                 is_sub ? (opa[WIDTH-1] != b_q[WIDTH-1]) & (raw[WIDTH-1] != opa[WIDTH-1]) : 1'b0;
    y_n        = (op_q == OP_AND)  ? opa & b_q :
                 (op_q == OP_OR)   ? opa | b_q :
                 (op_q == OP_XOR)  ? opa ^ b_q :
                 (op_q == OP_PASS) ? opa :
                 (op_q == OP_CLR)  ? '0 : raw[WIDTH-1:0];
    // clamping touches y only; carry/ovf still describe the unclamped result
    if (SATURATE && is_add && raw[WIDTH]) y_n = '1;
    if (SATURATE && is_sub && raw[WIDTH]) y_n = '0;
    s2_valid_d = xfer | (s2_valid_q & !out_ready);
    y_d        = xfer ? y_n : y_q;
    c_d        = xfer ? c_n : c_q;
    z_d        = xfer ? (y_n == '0) : z_q;
    n_d        = xfer ? y_n[WIDTH-1] : n_q;
    v_d        = xfer ? v_n : v_q;
    acc_d      = xfer ? y_n : acc_q;
    carry_d    = (xfer & (is_add | is_sub)) ? c_n : carry_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      acc_sel_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      acc_sel_q  <= acc_sel_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      c_q        <= c_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign carry     = c_q;
  assign zero      = z_q;
  assign neg       = n_q;
  assign ovf       = v_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench driving a plain and a saturating alu_pipe in lockstep
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, acc_sel;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_ready, out_valid, carry, zero, neg, ovf;
  logic [7:0] y;
  logic       in_ready_s, out_valid_s, carry_s, zero_s, neg_s, ovf_s;
  logic [7:0] y_s;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(8), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .acc_sel(acc_sel), .out_valid(out_valid), .out_ready(out_ready), .y(y), .carry(carry),
    .zero(zero), .neg(neg), .ovf(ovf));
  alu_pipe #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .op(op),
    .acc_sel(acc_sel), .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .carry(carry_s),
    .zero(zero_s), .neg(neg_s), .ovf(ovf_s));
  typedef struct packed {logic [7:0] y; logic c, z, n, v;} res_t;
  typedef struct packed {res_t p; res_t s;} exp_t;
  exp_t       sbq[$];
  exp_t       mon_e;
  int         out_cyc[$];
  int         checks = 0, errors = 0, cyc = 0, n_out = 0, n_base;
  logic [7:0] m_acc, m_acc_s;
  logic       m_c, m_c_s;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic res_t calc(input logic [2:0] f, input logic [7:0] x, input logic [7:0] w,
                                input logic cin, input bit sat);
    int   ux, uw, r, sx, sw, sr;
    res_t o;
    logic c, v;
    ux = x; uw = w; sx = $signed(x); sw = $signed(w);
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (f)
      3'd0: begin r = ux + uw; sr = sx + sw; c = r > 255; v = sr > 127 || sr < -128; end
      3'd6: begin r = ux + uw + int'(cin); sr = sx + sw + int'(cin); c = r > 255; v = sr > 127 || sr < -128; end
      3'd1: begin r = ux - uw; sr = sx - sw; c = ux < uw; v = sr > 127 || sr < -128; end
      3'd2: r = ux & uw;
      3'd3: r = ux | uw;
      3'd4: r = ux ^ uw;
      3'd5: r = ux;
      default: r = 0;
    endcase
    o.y = r[7:0];
    if (sat && c && (f == 3'd0 || f == 3'd6)) o.y = 8'hFF;
    if (sat && c && f == 3'd1) o.y = 8'h00;
    o.c = c;
    o.z = o.y == 8'h00;
    o.n = o.y[7];
    o.v = v;
    return o;
  endfunction
  task automatic push(input logic [2:0] f, input logic [7:0] x, input logic [7:0] w, input logic sel);
    exp_t e;
    e.p = calc(f, sel ? m_acc : x, w, m_c, 1'b0);
    e.s = calc(f, sel ? m_acc_s : x, w, m_c_s, 1'b1);
    m_acc = e.p.y;
    m_acc_s = e.s.y;
    if (f == 3'd0 || f == 3'd1 || f == 3'd6) begin
      m_c = e.p.c;
      m_c_s = e.s.c;
    end
    sbq.push_back(e);
  endtask
  task automatic send(input logic [2:0] f, input logic [7:0] x, input logic [7:0] w, input logic sel);
    bit ok = 0;
    op = f; a = x; b = w; acc_sel = sel; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push(f, x, w, sel);
        ok = 1;
        break;
      end
    end
    chk("send_accepted", 32'(ok), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      out_cyc.push_back(cyc);
      if (sbq.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("y", 32'(y), 32'(mon_e.p.y));
        chk("carry", 32'(carry), 32'(mon_e.p.c));
        chk("zero", 32'(zero), 32'(mon_e.p.z));
        chk("neg", 32'(neg), 32'(mon_e.p.n));
        chk("ovf", 32'(ovf), 32'(mon_e.p.v));
        chk("sat_valid", 32'(out_valid_s), 32'd1);
        chk("sat_y", 32'(y_s), 32'(mon_e.s.y));
        chk("sat_carry", 32'(carry_s), 32'(mon_e.s.c));
        chk("sat_zero", 32'(zero_s), 32'(mon_e.s.z));
        chk("sat_neg", 32'(neg_s), 32'(mon_e.s.n));
        chk("sat_ovf", 32'(ovf_s), 32'(mon_e.s.v));
      end
    end
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_sel = 1'b0; a = '0; b = '0; op = '0;
    m_acc = '0; m_acc_s = '0; m_c = 1'b0; m_c_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({carry, zero, neg, ovf}), 32'd0);
    chk("rst_sat_y", 32'(y_s), 32'd0);
    rst = 1'b0;
    send(3'd0, 8'h7F, 8'h01, 1'b0);
    drain();
    send(3'd1, 8'h03, 8'h05, 1'b0);
    drain();
    send(3'd0, 8'hFF, 8'h01, 1'b0);
    send(3'd6, 8'h00, 8'h00, 1'b0);
    drain();
    send(3'd2, 8'hF0, 8'h3C, 1'b0);
    send(3'd5, 8'h81, 8'h00, 1'b0);
    send(3'd1, 8'h80, 8'h01, 1'b0);
    drain();
    send(3'd7, 8'h00, 8'h00, 1'b0);
    drain();
    out_cyc.delete();
    for (int i = 0; i < 4; i++) send(3'd0, 8'h00, 8'h05, 1'b1);
    drain();
    chk("chain_count", 32'(out_cyc.size()), 32'd4);
    for (int i = 1; i < out_cyc.size(); i++) chk("chain_no_bubble", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
    n_base = n_out;
    out_ready = 1'b0;
    send(3'd4, 8'hA5, 8'h0F, 1'b0);
    send(3'd3, 8'h30, 8'h03, 1'b0);
    op = 3'd2; a = 8'hF0; b = 8'h3C; acc_sel = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_y_frozen", 32'(y), 32'(sbq[0].p.y));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(3'd2, 8'hF0, 8'h3C, 1'b0);
    drain();
    chk("stall_out_count", 32'(n_out - n_base), 32'd3);
    send(3'd0, 8'h10, 8'h20, 1'b0);
    send(3'd0, 8'h11, 8'h22, 1'b0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_flags", 32'({carry, zero, neg, ovf}), 32'd0);
    sbq.delete();
    m_acc = '0; m_acc_s = '0; m_c = 1'b0; m_c_s = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    send(3'd0, 8'h00, 8'h01, 1'b1);
    drain();
    chk("post_rst_acc_y", 32'(y), 32'h01);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
